uart_tx_arbiter: RTL

- Shares one UART transmitter between N_REQ byte producers using round-robin arbitration.
- Samples level requests, picks a winner, latches its byte, and issues a single-cycle tx_start to the transmitter.
- Waits for tx_done, then re-arbitrates.
- A watchdog aborts a transfer if the transmitter never completes.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_arbiter_rr_picker.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side blocks: state encoding,
// default byte width and a constant-friendly clog2.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_DATA_WIDTH = 8;

  // Returns at least 1 so single-entry indices still get a real bit.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Round-robin picker: finds the first set request strictly after 'last',
// wrapping around. Purely combinational.
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic             found,
  output logic [IDX_W-1:0] winner
);

  // rot[j] is the request of requester (last + 1 + j) mod N_REQ.
  logic [N_REQ-1:0] rot;
  logic [N_REQ:0]   seen;
  logic [N_REQ-1:0] first;
  logic [IDX_W-1:0] cand [N_REQ];
  logic [IDX_W-1:0] acc  [N_REQ+1];

  assign rot     = N_REQ'({req, req} >> (int'(last) + 1));
  assign seen[0] = 1'b0;
  assign acc[0]  = '0;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_scan
    assign first[gi]  = rot[gi] & ~seen[gi];
    assign seen[gi+1] = seen[gi] | rot[gi];
    assign cand[gi]   = IDX_W'((int'(last) + 1 + gi) % N_REQ);
    assign acc[gi+1]  = acc[gi] | (first[gi] ? cand[gi] : '0);
  end

  assign found  = seen[N_REQ];
  assign winner = acc[N_REQ];

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter between N_REQ byte producers,
// with a watchdog that abandons a transfer the transmitter never finishes.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            grant,
  output logic                        tx_start,
  output logic [DATA_WIDTH-1:0]       tx_data,
  input  logic                        tx_busy,
  input  logic                        tx_done,
  output logic [clog2(N_REQ)-1:0]     owner,
  output logic                        active,
  output logic                        timeout_err
);

  localparam int IDX_W = clog2(N_REQ);
  localparam int CNT_W = clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                state_reg, state_next;
  logic [IDX_W-1:0]      last_reg, last_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [N_REQ-1:0]      grant_reg, grant_next;
  logic                  tx_start_reg, tx_start_next;
  logic [DATA_WIDTH-1:0] tx_data_reg, tx_data_next;
  logic [IDX_W-1:0]      owner_reg, owner_next;
  logic                  active_reg, active_next;
  logic                  timeout_err_reg, timeout_err_next;

  logic                  pick_found;
  logic [IDX_W-1:0]      pick_winner;

  rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req    (req),
    .last   (last_reg),
    .found  (pick_found),
    .winner (pick_winner)
  );

  always_comb begin
    state_next       = state_reg;
    last_next        = last_reg;
    cnt_next         = cnt_reg;
    grant_next       = '0;
    tx_start_next    = 1'b0;
    tx_data_next     = tx_data_reg;
    owner_next       = owner_reg;
    active_next      = active_reg;
    timeout_err_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!tx_busy && pick_found) begin
          state_next    = LOAD;
          last_next     = pick_winner;
          owner_next    = pick_winner;
          tx_data_next  = req_data[pick_winner*DATA_WIDTH +: DATA_WIDTH];
          grant_next    = N_REQ'(1) << pick_winner;
          tx_start_next = 1'b1;
          active_next   = 1'b1;
        end
      end
      LOAD: begin
        state_next = WAIT_DONE;
        cnt_next   = '0;
      end
      WAIT_DONE: begin
        // A completion in the final watchdog cycle still counts as success.
        if (tx_done) begin
          state_next  = IDLE;
          active_next = 1'b0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next       = IDLE;
          active_next      = 1'b0;
          timeout_err_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next  = IDLE;
        active_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      last_reg        <= IDX_W'(N_REQ - 1);
      cnt_reg         <= '0;
      grant_reg       <= '0;
      tx_start_reg    <= 1'b0;
      tx_data_reg     <= '0;
      owner_reg       <= '0;
      active_reg      <= 1'b0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      last_reg        <= last_next;
      cnt_reg         <= cnt_next;
      grant_reg       <= grant_next;
      tx_start_reg    <= tx_start_next;
      tx_data_reg     <= tx_data_next;
      owner_reg       <= owner_next;
      active_reg      <= active_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

  assign grant       = grant_reg;
  assign tx_start    = tx_start_reg;
  assign tx_data     = tx_data_reg;
  assign owner       = owner_reg;
  assign active      = active_reg;
  assign timeout_err = timeout_err_reg;

endmodule
